// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-requester rotate arbiter.
// Holds the FSM state encoding, default geometry and requester IDs.
package shift_arbiter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SHW   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Round-robin hand-off: after a grant the pointer favours the other side.
    function automatic logic other_src(input logic src);
        return (src == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/shift_arbiter_rot_core.sv
// Combinational barrel rotator: dir = 0 rotates right, dir = 1 rotates left.
// Assumes SHW = log2(WIDTH), so every amount is below WIDTH.
module rot_core
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    input  logic             dir,
    output logic [WIDTH-1:0] result
);

    localparam logic [SHW:0] FULL = (SHW + 1)'(WIDTH);

    logic [SHW:0] right_amt;

    // A left rotate by s is a right rotate by (WIDTH - s) mod WIDTH, so one
    // shifter over the doubled word covers both directions.
    // NOTE: every always_comb output is given a value before any branch so no latch can be inferred.
    always_comb begin
        right_amt = {1'b0, amount};
        if (dir && (amount != '0)) begin
            right_amt = FULL - {1'b0, amount};
        end
        result = WIDTH'({data, data} >> right_amt);
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter between two rotate requesters with a one-deep,
// ready/valid-handshaked result register and a completed-transfer counter.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic [SHW-1:0]   shift_a,
    input  logic             dir_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic [SHW-1:0]   shift_b,
    input  logic             dir_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [7:0]       done_cnt
);

    state_t           state_q, state_d;
    logic             ptr_q;
    logic             win_src;
    logic             capture;
    logic             complete;
    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_shift;
    logic             sel_dir;
    logic [WIDTH-1:0] rot_result;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        win_src = SRC_A;
        if (req_a && req_b) begin
            win_src = ptr_q;
        end else if (req_b) begin
            win_src = SRC_B;
        end
    end

    assign capture  = (state_q == IDLE) && (req_a || req_b);
    assign complete = (state_q == HOLD) && out_ready;

    assign sel_data  = (win_src == SRC_B) ? data_b  : data_a;
    assign sel_shift = (win_src == SRC_B) ? shift_b : shift_a;
    assign sel_dir   = (win_src == SRC_B) ? dir_b   : dir_a;

    rot_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_rot (
        .data   (sel_data),
        .amount (sel_shift),
        .dir    (sel_dir),
        .result (rot_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion always lands in IDLE, which forces one idle cycle between results.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_a || req_b) state_d = HOLD;
            HOLD:    if (out_ready)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == HOLD);

    // NOTE: every datapath flop is reset, so a cleared block never shows a stale result.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            data_out <= '0;
            out_src  <= SRC_A;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            ptr_q    <= SRC_A;
            done_cnt <= 8'd0;
        end else begin
            gnt_a <= capture && (win_src == SRC_A);
            gnt_b <= capture && (win_src == SRC_B);
            if (capture) begin
                data_out <= rot_result;
                out_src  <= win_src;
                ptr_q    <= other_src(win_src);
            end
            if (complete) begin
                done_cnt <= done_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       clear;
    logic       req_a, req_b;
    logic [7:0] data_a, data_b;
    logic [2:0] shift_a, shift_b;
    logic       dir_a, dir_b;
    logic       gnt_a, gnt_b;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       out_src;
    logic [7:0] done_cnt;

    int checks = 0;
    int errors = 0;

    shift_arbiter dut (
        .clk       (clk),
        .clear     (clear),
        .req_a     (req_a),
        .data_a    (data_a),
        .shift_a   (shift_a),
        .dir_a     (dir_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .shift_b   (shift_b),
        .dir_b     (dir_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit-level rotate from the definition: right by r means out[i] = in[(i+r) mod 8].
    function automatic logic [7:0] rot_ref(input logic [7:0] d, input int s, input logic dir);
        logic [7:0] r;
        int amt;
        amt = dir ? ((8 - s) % 8) : s;
        for (int i = 0; i < 8; i++) r[i] = d[(i + amt) % 8];
        return r;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        clear = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        clear = 1'b1;
    endtask

    typedef struct {
        logic       src;
        logic [7:0] data;
        logic [2:0] shift;
        logic       dir;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   exp_cnt;
        logic exp_ga[6];
        logic exp_gb[6];
        logic [7:0] exp_c[6];
        logic m_busy, m_src, m_ga, m_gb, m_ptr, w;
        logic [7:0] m_data;
        logic [7:0] m_cnt;

        vecs[0] = '{1'b0, 8'hB1, 3'd1, 1'b0, 8'hD8};
        vecs[1] = '{1'b1, 8'h81, 3'd7, 1'b1, 8'hC0};
        vecs[2] = '{1'b1, 8'h81, 3'd0, 1'b1, 8'h81};
        vecs[3] = '{1'b0, 8'h81, 3'd0, 1'b0, 8'h81};
        vecs[4] = '{1'b0, 8'hF0, 3'd4, 1'b1, 8'h0F};
        vecs[5] = '{1'b1, 8'h01, 3'd7, 1'b0, 8'h02};
        vecs[6] = '{1'b0, 8'h80, 3'd1, 1'b1, 8'h01};
        vecs[7] = '{1'b1, 8'hA5, 3'd3, 1'b0, 8'hB4};

        clear = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
        data_a = '0; data_b = '0; shift_a = '0; shift_b = '0; dir_a = 1'b0; dir_b = 1'b0;

        // Reset state while clear is held low.
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_gnt", {gnt_a, gnt_b}, 0);
        check("rst_src", out_src, 0);
        check("rst_cnt", done_cnt, 0);
        @(negedge clk);
        clear = 1'b1;

        // out_ready while idle has no effect.
        @(negedge clk); out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_cnt", done_cnt, 0);
        check("idle_ready_valid", out_valid, 0);

        // Directed rotate vectors, one isolated transfer each.
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            req_a = (vecs[i].src == 1'b0);
            req_b = (vecs[i].src == 1'b1);
            data_a = vecs[i].data; shift_a = vecs[i].shift; dir_a = vecs[i].dir;
            data_b = vecs[i].data; shift_b = vecs[i].shift; dir_b = vecs[i].dir;
            @(posedge clk); #1;
            check($sformatf("vec%0d_gnt", i), {gnt_a, gnt_b}, vecs[i].src ? 2'b01 : 2'b10);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp);
            check($sformatf("vec%0d_src", i), out_src, vecs[i].src);
            @(negedge clk);
            req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            exp_cnt++;
            check($sformatf("vec%0d_done_valid", i), out_valid, 0);
            check($sformatf("vec%0d_cnt", i), done_cnt, exp_cnt);
        end

        // Both requesting from reset with out_ready high: A, B, A.
        reset_dut();
        exp_ga = '{1, 0, 0, 0, 1, 0};
        exp_gb = '{0, 0, 1, 0, 0, 0};
        exp_c  = '{0, 1, 1, 2, 2, 3};
        @(negedge clk);
        req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
        data_a = 8'h11; shift_a = 3'd0; data_b = 8'h22; shift_b = 3'd0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("rr%0d_gnt_a", c), gnt_a, exp_ga[c]);
            check($sformatf("rr%0d_gnt_b", c), gnt_b, exp_gb[c]);
            check($sformatf("rr%0d_cnt", c), done_cnt, exp_c[c]);
            if (exp_ga[c]) check($sformatf("rr%0d_data", c), data_out, 8'h11);
            if (exp_gb[c]) check($sformatf("rr%0d_data", c), data_out, 8'h22);
        end
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;

        // HOLD back-pressure: requests ignored, result stable, then one IDLE cycle.
        reset_dut();
        @(negedge clk);
        req_a = 1'b1; data_a = 8'h3C; shift_a = 3'd2; dir_a = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        check("hold_cap_gnt", gnt_a, 1);
        check("hold_cap_data", data_out, 8'hF0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_a = c[0];
            data_a = 8'($urandom);
            @(posedge clk); #1;
            check($sformatf("hold%0d_gnt", c), {gnt_a, gnt_b}, 0);
            check($sformatf("hold%0d_valid", c), out_valid, 1);
            check($sformatf("hold%0d_data", c), data_out, 8'hF0);
        end
        @(negedge clk);
        out_ready = 1'b1; req_a = 1'b1; data_a = 8'h12; shift_a = 3'd4; dir_a = 1'b0;
        @(posedge clk); #1;
        check("release_valid", out_valid, 0);
        check("release_gnt", gnt_a, 0);
        check("release_cnt", done_cnt, 1);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("next_cap_gnt", gnt_a, 1);
        check("next_cap_data", data_out, 8'h21);

        // clear mid-HOLD discards the result and resets the pointer to A.
        @(negedge clk);
        req_a = 1'b0;
        #2 clear = 1'b0;
        #1;
        check("clr_valid", out_valid, 0);
        check("clr_data", data_out, 0);
        check("clr_cnt", done_cnt, 0);
        check("clr_src", out_src, 0);
        check("clr_gnt", {gnt_a, gnt_b}, 0);
        @(negedge clk);
        clear = 1'b1;
        req_a = 1'b1; req_b = 1'b1; out_ready = 1'b0;
        data_a = 8'h0F; shift_a = 3'd1; dir_a = 1'b1;
        data_b = 8'hAA; shift_b = 3'd1; dir_b = 1'b0;
        @(posedge clk); #1;
        check("post_clr_gnt", {gnt_a, gnt_b}, 2'b10);
        check("post_clr_src", out_src, 0);
        check("post_clr_data", data_out, 8'h1E);
        check("post_clr_cnt", done_cnt, 0);

        // done_cnt wrap after 256 completed transfers.
        reset_dut();
        @(negedge clk);
        req_a = 1'b1; req_b = 1'b0; out_ready = 1'b1;
        repeat (510) @(posedge clk);
        #1;
        check("cnt_255", done_cnt, 255);
        repeat (2) @(posedge clk);
        #1;
        check("cnt_wrap", done_cnt, 0);

        // Randomized run against a transaction-level model.
        reset_dut();
        m_busy = 0; m_src = 0; m_ga = 0; m_gb = 0; m_ptr = 0; m_data = '0; m_cnt = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            req_a = ($urandom_range(0, 1) == 1);
            req_b = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            data_a = 8'($urandom); shift_a = 3'($urandom); dir_a = 1'($urandom);
            data_b = 8'($urandom); shift_b = 3'($urandom); dir_b = 1'($urandom);
            m_ga = 0; m_gb = 0;
            if (m_busy) begin
                if (out_ready) begin
                    m_busy = 0;
                    m_cnt = m_cnt + 8'd1;
                end
            end else if (req_a || req_b) begin
                w = (req_a && req_b) ? m_ptr : !req_a;
                m_data = w ? rot_ref(data_b, shift_b, dir_b) : rot_ref(data_a, shift_a, dir_a);
                m_src = w;
                m_ga = !w;
                m_gb = w;
                m_ptr = !w;
                m_busy = 1;
            end
            @(posedge clk); #1;
            check("rnd_gnt_a", gnt_a, m_ga);
            check("rnd_gnt_b", gnt_b, m_gb);
            check("rnd_gnt_excl", gnt_a & gnt_b, 0);
            check("rnd_valid", out_valid, m_busy);
            check("rnd_cnt", done_cnt, m_cnt);
            if (m_busy) begin
                check("rnd_data", data_out, m_data);
                check("rnd_src", out_src, m_src);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter SHW, default 3, shift-amount width (log2 WIDTH).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port clear  input  1  reset, asynchronous and active-low.
REQ-005 Port req_a  input  1  requester A has an operation pending.
REQ-006 Port data_a  input  WIDTH  requester A operand.
REQ-007 Port shift_a  input  SHW  requester A rotate amount.
REQ-008 Port dir_a  input  1  requester A direction (0 = rotate right, 1 = rotate left).
REQ-009 Ports req_b, data_b, shift_b, dir_b SHALL mirror REQ-005..008 for requester B.
REQ-010 Port gnt_a  output  1  one-cycle pulse: A's operation captured.
REQ-011 Port gnt_b  output  1  one-cycle pulse: B's operation captured.
REQ-012 Port data_out  output  WIDTH  registered rotate result.
REQ-013 Port out_valid  output  1  data_out holds an unconsumed result.
REQ-014 Port out_ready  input  1  consumer accepts data_out when high with out_valid.
REQ-015 Port out_src  output  1  source of current result (0 = A, 1 = B).
REQ-016 Port done_cnt  output  8  count of completed transfers, wraps 255 -> 0.

Function
REQ-017 The FSM SHALL have two states: IDLE (out_valid = 0) and HOLD (out_valid = 1).
REQ-018 In IDLE with req_a or req_b high at a rising edge, the block SHALL capture the winner's rotate result, enter HOLD, and pulse the winner's gnt for exactly the following cycle.
REQ-019 Latency SHALL be one cycle: out_valid and the matching gnt rise together on the edge after capture.
REQ-020 Arbitration SHALL be round-robin: a priority pointer selects the winner when both requesters are high; after any grant it points to the other requester.
REQ-021 With only one requester high, that requester SHALL win regardless of the pointer.
REQ-022 Result SHALL be data rotated right by shift when dir = 0, and rotated left by shift when dir = 1; left by s equals right by (WIDTH - s) mod WIDTH.
REQ-023 Shift 0 SHALL pass data unchanged in either direction; no bits are lost (rotate, not shift).
REQ-024 In HOLD, requests SHALL be ignored and data_out, out_src SHALL stay stable until out_valid && out_ready.
REQ-025 On out_valid && out_ready, the block SHALL return to IDLE and increment done_cnt modulo 256.
REQ-026 No IDLE-to-HOLD transition SHALL occur in the edge that completes a transfer; a new capture needs at least one IDLE cycle (maximum throughput one result per 2 cycles).
REQ-027 Requesters SHALL hold req, data, shift and dir stable until their gnt and SHALL deassert req in the gnt cycle; req still high after gnt is a new request.
REQ-028 out_ready while out_valid = 0 SHALL have no effect.
REQ-029 gnt_a and gnt_b SHALL never be high in the same cycle.

Reset
REQ-030 clear low SHALL immediately force: state IDLE, data_out 0, out_valid 0, gnt_a 0, gnt_b 0, out_src 0, done_cnt 0, pointer to A.
REQ-031 Assertion of clear in HOLD SHALL discard the pending result with no done_cnt increment; the first grant after release obeys REQ-021 and REQ-030.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, HOLD), WIDTH/SHW defaults and the requester-ID constants (SRC_A = 0, SRC_B = 1).
REQ-033 Rotation SHALL live in one combinational sub-module, rot_core (data, amount, dir -> result); the arbiter and FSM stay in shift_arbiter.

Verification
REQ-034 Reset, then req_a with data_a = 8'hB1, shift_a = 1, dir_a = 0 -> gnt_a pulse; data_out = 8'hD8; out_valid = 1; out_src = 0.
REQ-035 req_a and req_b both high from reset, out_ready = 1 throughout -> grants alternate A, B, A; done_cnt reaches 3.
REQ-036 req_b with data_b = 8'h81, shift_b = 7, dir_b = 1 -> data_out = 8'hC0; shift_b = 0 gives 8'h81.
REQ-037 out_ready = 0 for 5 cycles in HOLD while req_a toggles -> data_out stable, no gnt; out_ready = 1 -> one IDLE cycle, then the next capture.
REQ-038 clear pulsed low mid-HOLD -> outputs and done_cnt read 0 at once; pending result never appears.
REQ-039 256 completed transfers -> done_cnt wraps to 0.
